// File: rtl/mips_dmem_responder_pkg.sv
// Shared types and constants for the MIPS data-memory responder.
// The statistics helper is only referenced when MIPS_DMEM_STATS_EN is defined.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int STAT_W     = 16;

    function automatic logic is_misaligned(input logic [$clog2(WORD_BYTES)-1:0] byte_off);
        return byte_off != '0;
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (value == '1) ? value : value + STAT_W'(1);
    endfunction

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Core-to-memory request/response bundle for the MIPS data-memory port.
// The core drives the master side; the responder is the slave.
interface mips_dmem_if;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, err
    );

endinterface

// File: rtl/mips_dmem_responder_array.sv
// DEPTH x 32 word storage: synchronous write, asynchronous read, both by word index.
module dmem_array #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_idx,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // NOTE: the storage has no reset; clearing a RAM needs a sweep, and contents must survive init.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mips_dmem_responder.sv
// Slow data-memory responder with programmable wait states, ready handshake and error flagging.
// Optional MIPS_DMEM_STATS_EN adds saturating read/write/error response counters.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              init,
    mips_dmem_if.slave        bus
`ifdef MIPS_DMEM_STATS_EN
    ,
    output logic [STAT_W-1:0] rd_count,
    output logic [STAT_W-1:0] wr_count,
    output logic [STAT_W-1:0] err_count
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int OFF_W = $clog2(WORD_BYTES);
    localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    dmem_state_t r_state;
    dmem_state_t w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_is_write;
    logic          r_ready;
    logic          r_err;

    logic [31:0]   w_req_addr;
    logic [31:0]   w_req_wdata;
    logic          w_req_write;
    logic          w_req_both;
    logic          w_req_err;
    logic          w_enter_resp;
    logic          w_commit_wr;
    logic          w_load_rd;
    logic [31:0]   w_arr_rdata;

    // With zero wait states IDLE jumps straight to RESP, so the live bus is the request.
    assign w_req_addr   = (r_state == IDLE) ? bus.addr      : r_addr;
    assign w_req_wdata  = (r_state == IDLE) ? bus.wdata     : r_wdata;
    assign w_req_write  = (r_state == IDLE) ? bus.mem_write : r_is_write;
    assign w_req_both   = (r_state == IDLE) & bus.mem_read & bus.mem_write;
    assign w_req_err    = w_req_both
                        | is_misaligned(w_req_addr[OFF_W-1:0])
                        | (|w_req_addr[31:AW+OFF_W]);
    assign w_enter_resp = (w_next == RESP) && (r_state != RESP);
    assign w_commit_wr  = w_enter_resp & w_req_write & ~w_req_err;
    assign w_load_rd    = w_enter_resp & ~w_req_write & ~w_req_err;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .i_we    (w_commit_wr),
        .i_idx   (w_req_addr[AW+OFF_W-1:OFF_W]),
        .i_wdata (w_req_wdata),
        .o_rdata (w_arr_rdata)
    );

    // NOTE: next state takes its default first so no path through the case can infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.mem_read & bus.mem_write) begin
                    w_next = RESP;
                end else if (bus.mem_read ^ bus.mem_write) begin
                    if (WAIT_CYCLES == 0) w_next = RESP;
                    else                  w_next = WAIT;
                end
            end
            WAIT: begin
                if (r_is_write ? !bus.mem_write : !bus.mem_read) begin
                    w_next = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignment so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= w_enter_resp;
            r_err   <= w_enter_resp & w_req_err;
            if (r_state == IDLE) begin
                r_addr     <= bus.addr;
                r_wdata    <= bus.wdata;
                r_is_write <= bus.mem_write;
                r_cnt      <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_load_rd) begin
                r_rdata <= w_arr_rdata;
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ready = r_ready;
    assign bus.err   = r_err;

`ifdef MIPS_DMEM_STATS_EN
    logic [STAT_W-1:0] r_rd_count;
    logic [STAT_W-1:0] r_wr_count;
    logic [STAT_W-1:0] r_err_count;

    // Counted during the RESP cycle; an illegal both-set request counts only as an error.
    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            r_rd_count  <= '0;
            r_wr_count  <= '0;
            r_err_count <= '0;
        end else if (r_ready) begin
            if (r_err)           r_err_count <= sat_inc(r_err_count);
            else if (r_is_write) r_wr_count  <= sat_inc(r_wr_count);
            else                 r_rd_count  <= sat_inc(r_rd_count);
        end
    end

    assign rd_count  = r_rd_count;
    assign wr_count  = r_wr_count;
    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench for mips_dmem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
// Stats checks are active when MIPS_DMEM_STATS_EN is defined.
module tb_mips_dmem_responder;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic init;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t vecs[14];

    mips_dmem_if bus0();
    mips_dmem_if bus1();

`ifdef MIPS_DMEM_STATS_EN
    logic [15:0] rd0, wr0, er0, rd1, wr1, er1;
`endif

    mips_dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut0 (
        .clk       (clk),
        .init      (init),
        .bus       (bus0)
`ifdef MIPS_DMEM_STATS_EN
        ,
        .rd_count  (rd0),
        .wr_count  (wr0),
        .err_count (er0)
`endif
    );

    mips_dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut1 (
        .clk       (clk),
        .init      (init),
        .bus       (bus1)
`ifdef MIPS_DMEM_STATS_EN
        ,
        .rd_count  (rd1),
        .wr_count  (wr1),
        .err_count (er1)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            bus0.mem_read = rd; bus0.mem_write = wr; bus0.addr = a; bus0.wdata = wd;
        end else begin
            bus1.mem_read = rd; bus1.mem_write = wr; bus1.addr = a; bus1.wdata = wd;
        end
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? bus0.ready : bus1.ready;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? bus0.err : bus1.err;
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? bus0.rdata : bus1.rdata;
    endfunction

    // Issues one request, holds it until ready (bounded), then checks the response.
    task automatic do_req(input int d, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rdata,
                          input int exp_lat, input string name);
        exp_t e;
        int   k;
        bit   seen;
        e.err   = exp_err;
        e.rdata = exp_rdata;
        e.lat   = exp_lat;
        sb.push_back(e);
        drive(d, rd, wr, a, wd);
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (get_ready(d)) seen = 1'b1;
        end
        e = sb.pop_front();
        check({name, "/ready"},   32'(seen), 32'd1);
        check({name, "/latency"}, k, e.lat);
        check({name, "/err"},     32'(get_err(d)), 32'(e.err));
        check({name, "/rdata"},   get_rdata(d), e.rdata);
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check({name, "/one_pulse"}, 32'(get_ready(d) | get_err(d)), 32'd0);
    endtask

    initial begin
        int pulses;

        //          rd    wr    addr        wdata         err   rdata
        vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h13,  32'h0,        1'b1, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b0, 32'h400, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'h0,   32'h11111111, 1'b0, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 1'b1, 32'h400, 32'hBADBAD00, 1'b1, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h11111111};
        vecs[7]  = '{1'b0, 1'b1, 32'h3FC, 32'h12345678, 1'b0, 32'h11111111};
        vecs[8]  = '{1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, 32'h12345678};
        vecs[9]  = '{1'b1, 1'b1, 32'h10,  32'h0,        1'b1, 32'h12345678};
        vecs[10] = '{1'b0, 1'b1, 32'h12,  32'hFFFFFFFF, 1'b1, 32'h12345678};
        vecs[11] = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
        vecs[12] = '{1'b0, 1'b1, 32'h10,  32'hCAFEF00D, 1'b0, 32'hDEADBEEF};
        vecs[13] = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hCAFEF00D};

        init = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        check("reset/ready0", 32'(bus0.ready), 32'd0);
        check("reset/err0",   32'(bus0.err),   32'd0);
        check("reset/rdata0", bus0.rdata,      32'h0);
        check("reset/ready1", 32'(bus1.ready), 32'd0);
        check("reset/rdata1", bus1.rdata,      32'h0);
        @(negedge clk);
        init = 1'b1;
        @(posedge clk); #1;

        // Both-set requests skip the wait states and answer in one clock.
        for (int i = 0; i < 14; i++) begin
            do_req(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].err, vecs[i].rdata,
                   (vecs[i].rd & vecs[i].wr) ? 1 : 3, $sformatf("vec%0d", i));
        end

        // Abort: write dropped in the first wait cycle must not commit or respond.
        do_req(0, 1'b0, 1'b1, 32'h20, 32'h55555555, 1'b0, 32'hCAFEF00D, 3, "w20");
        drive(0, 1'b0, 1'b1, 32'h20, 32'hAAAAAAAA);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h20, 32'hAAAAAAAA);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus0.ready) pulses++;
        end
        check("abort/no_ready", pulses, 0);
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h55555555, 3, "abort/r20");

        // Reset during the wait of a write: outputs clear at once, array keeps old word.
        drive(0, 1'b0, 1'b1, 32'h20, 32'h77777777);
        @(posedge clk); #1;
        @(posedge clk); #1;
        init = 1'b0;
        #1;
        check("rst_mid/ready", 32'(bus0.ready), 32'd0);
        check("rst_mid/err",   32'(bus0.err),   32'd0);
        check("rst_mid/rdata", bus0.rdata,      32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        init = 1'b1;
        @(posedge clk); #1;
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h55555555, 3, "rst_mid/r20");

        // Zero wait states: back-to-back write then read, one clock each.
        do_req(1, 1'b0, 1'b1, 32'h8, 32'h0BADF00D, 1'b0, 32'h0,        1, "z/w8");
        do_req(1, 1'b1, 1'b0, 32'h8, 32'h0,        1'b0, 32'h0BADF00D, 1, "z/r8");
        do_req(1, 1'b1, 1'b0, 32'h3, 32'h0,        1'b1, 32'h0BADF00D, 1, "z/rmis");
`ifdef MIPS_DMEM_STATS_EN
        check("stats/wr_count",  32'(wr1), 32'd1);
        check("stats/rd_count",  32'(rd1), 32'd1);
        check("stats/err_count", 32'(er1), 32'd1);
        check("stats/dut0_wr",   32'(wr0), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
